// File: rtl/fp_norm_round_pkg.sv
// Shared single-precision constants and pipeline stage records for the
// normalise/round/pack stage behind the FP add/sub datapath.
package fp_norm_round_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int SIG_W   = MAN_W + 1;
    localparam int XEXP_W  = EXP_W + 2;
    localparam int EXP_MAX = 255;

    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Detect stage: significand already pre-shifted on carry-out.
    typedef struct packed {
        logic              sign;
        logic [XEXP_W-1:0] exp;
        logic [SIG_W-1:0]  mant;
        logic [2:0]        grs;
        logic [4:0]        lzc;
        logic              special;
        logic              zero;
    } s1_t;

    // Shift/round stage: rounded fraction plus classification for packing.
    typedef struct packed {
        logic              sign;
        logic [XEXP_W-1:0] exp;
        logic [MAN_W-1:0]  frac;
        logic              special;
        logic              zero;
        logic              uf;
        logic              inexact;
    } s2_t;

endpackage

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; all-zero input yields 24.
module fp_lzc24 (
    input  logic [23:0] mant_i,
    output logic [4:0]  lzc_o
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        lzc_o = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (mant_i[i]) lzc_o = 5'(23 - i);
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Three-stage normalise / round-to-nearest-even / pack stage producing an
// IEEE-754 single from the raw adder result, with flush-to-zero.
module fp_norm_round
    import fp_norm_round_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic        in_carry,
    input  logic [23:0] in_mant,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_of,
    output logic        out_uf,
    output logic        out_inexact
);

    // Handshake: a beat moves on a cycle where valid && ready. The whole pipe
    // advances together whenever the output slot is empty or being taken, so
    // in_ready is that same advance term and bubbles travel with the beats.
    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    logic        v1_q, v2_q, out_valid_q;
    s1_t         s1_d, s1_q;
    s2_t         s2_d, s2_q;
    logic [31:0] data_d, data_q;
    logic [2:0]  flags_d, flags_q;
    logic [4:0]  lzc_raw;

    fp_lzc24 u_lzc (
        .mant_i (in_mant),
        .lzc_o  (lzc_raw)
    );

    always_comb begin
        s1_d         = '0;
        s1_d.sign    = in_sign;
        s1_d.exp     = {2'b00, in_exp};
        s1_d.mant    = in_mant;
        s1_d.grs     = in_grs;
        s1_d.lzc     = lzc_raw;
        s1_d.special = (in_exp == 8'(EXP_MAX));
        if (s1_d.special) begin
            s1_d.lzc = 5'd0;
        end else if (in_carry) begin
            // Value >= 2.0: shift right one, old LSB becomes guard.
            s1_d.mant = {1'b1, in_mant[23:1]};
            s1_d.grs  = {in_mant[0], in_grs[2], |in_grs[1:0]};
            s1_d.exp  = s1_d.exp + 10'd1;
            s1_d.lzc  = 5'd0;
        end else begin
            s1_d.zero = (in_mant == '0) && (in_grs == '0);
        end
    end

    logic [26:0] wide;
    logic [23:0] mant_s;
    logic [2:0]  grs_s;
    logic        round_up, flush;
    logic [24:0] rsum;

    always_comb begin
        wide     = {s1_q.mant, s1_q.grs} << s1_q.lzc;
        mant_s   = wide[26:3];
        grs_s    = wide[2:0];
        round_up = grs_s[2] & (grs_s[1] | grs_s[0] | mant_s[0]);
        rsum     = {1'b0, mant_s} + {24'd0, round_up};
        flush    = !s1_q.special && !s1_q.zero &&
                   ($signed(s1_q.exp) <= $signed({5'd0, s1_q.lzc}));

        s2_d         = '0;
        s2_d.sign    = s1_q.sign;
        s2_d.special = s1_q.special;
        s2_d.zero    = s1_q.zero;
        s2_d.uf      = flush;
        s2_d.exp     = s1_q.exp - {5'd0, s1_q.lzc} + {9'd0, rsum[24]};
        // A rounding carry leaves 1.0 in rsum[24]; renormalise by one.
        s2_d.frac    = rsum[24] ? rsum[23:1] : rsum[22:0];
        s2_d.inexact = flush | (|grs_s);
        if (s1_q.special) begin
            s2_d.exp     = s1_q.exp;
            s2_d.frac    = s1_q.mant[22:0];
            s2_d.inexact = 1'b0;
        end
    end

    always_comb begin
        data_d  = {s2_q.sign, s2_q.exp[7:0], s2_q.frac};
        flags_d = '0;
        flags_d[FLAG_NX] = s2_q.inexact;
        if (s2_q.special) begin
            data_d  = {s2_q.sign, 8'hFF, s2_q.frac};
            flags_d = '0;
        end else if (s2_q.zero || s2_q.uf) begin
            data_d           = {s2_q.sign, 31'd0};
            flags_d[FLAG_UF] = s2_q.uf;
        end else if (s2_q.exp >= 10'(EXP_MAX)) begin
            data_d           = {s2_q.sign, 8'hFF, 23'd0};
            flags_d[FLAG_OF] = 1'b1;
            flags_d[FLAG_NX] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            data_q      <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            v1_q        <= in_valid;
            s1_q        <= s1_d;
            v2_q        <= v1_q;
            s2_q        <= s2_d;
            out_valid_q <= v2_q;
            data_q      <= data_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = data_q;
    assign out_of      = flags_q[FLAG_OF];
    assign out_uf      = flags_q[FLAG_UF];
    assign out_inexact = flags_q[FLAG_NX];

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: hand-computed vectors through a
// scoreboard queue, plus latency, backpressure and mid-stream reset.
module tb_fp_norm_round;

    localparam int W = 35;

    logic        clk, rst;
    logic        in_valid, in_ready, in_sign, in_carry;
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic [2:0]  in_grs;
    logic        out_valid, out_ready, out_of, out_uf, out_inexact;
    logic [31:0] out_data;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks, n_errors, n_out;

    fp_norm_round dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_carry    (in_carry),
        .in_mant     (in_mant),
        .in_grs      (in_grs),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_of      (out_of),
        .out_uf      (out_uf),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input string tag, input logic s, input logic [7:0] e, input logic c,
                        input logic [23:0] m, input logic [2:0] g,
                        input logic [31:0] d, input logic [2:0] f);
        int n;
        exp_q.push_back({d, f});
        tag_q.push_back(tag);
        in_sign  = s;
        in_exp   = e;
        in_carry = c;
        in_mant  = m;
        in_grs   = g;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("extra_beat", exp_q.size(), 1);
            end else begin
                check(tag_q.pop_front(), {out_data, out_of, out_uf, out_inexact}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int lat;
        int n_snap;
        n_checks  = 0;
        n_errors  = 0;
        n_out     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_carry  = 1'b0;
        in_mant   = '0;
        in_grs    = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flags", {out_of, out_uf, out_inexact}, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: 1.5*2^1 + 1.25*2^2 = 8.0.
        send("add_8p0", 0, 8'd129, 1, 24'h000000, 3'b000, 32'h41000000, 3'b000);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        drain();

        // Flags are {of, uf, inexact}.
        send("rne_tie_up",   0, 8'd127, 0, 24'hFFFFFF, 3'b100, 32'h40000000, 3'b001);
        send("norm_lzc23",   1, 8'd127, 0, 24'h000001, 3'b000, 32'hB4000000, 3'b000);
        send("overflow",     0, 8'd254, 1, 24'h800000, 3'b000, 32'h7F800000, 3'b101);
        send("uf_flush",     0, 8'd10,  0, 24'h000100, 3'b000, 32'h00000000, 3'b011);
        send("exact_zero",   0, 8'd100, 0, 24'h000000, 3'b000, 32'h00000000, 3'b000);
        send("neg_zero",     1, 8'd100, 0, 24'h000000, 3'b000, 32'h80000000, 3'b000);
        send("special_nan",  0, 8'd255, 0, 24'hC00001, 3'b000, 32'h7FC00001, 3'b000);
        send("special_inf",  1, 8'd255, 1, 24'h800000, 3'b111, 32'hFF800000, 3'b000);
        send("rne_down",     0, 8'd127, 0, 24'h800000, 3'b011, 32'h3F800000, 3'b001);
        send("rne_tie_even", 0, 8'd127, 0, 24'h800000, 3'b100, 32'h3F800000, 3'b001);
        send("rne_up",       0, 8'd127, 0, 24'h800000, 3'b110, 32'h3F800001, 3'b001);
        send("rne_tie_odd",  0, 8'd127, 0, 24'h800001, 3'b100, 32'h3F800002, 3'b001);
        send("flush_edge",   0, 8'd1,   0, 24'h400000, 3'b000, 32'h00000000, 3'b011);
        send("norm_edge",    0, 8'd2,   0, 24'h400000, 3'b000, 32'h00800000, 3'b000);
        send("shift_grs",    0, 8'd127, 0, 24'h400000, 3'b100, 32'h3F000001, 3'b000);
        send("carry_sticky", 0, 8'd127, 1, 24'h000003, 3'b000, 32'h40000002, 3'b001);
        send("neg_flush",    1, 8'd3,   0, 24'h000100, 3'b000, 32'h80000000, 3'b011);
        send("round_of",     0, 8'd254, 0, 24'hFFFFFF, 3'b100, 32'h7F800000, 3'b101);
        drain();

        // Six beats with the consumer stalled for five cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send($sformatf("bp_%0d", i), 0, 8'(127 + i), 0, 24'h800000 | 24'(i), 3'b000,
                         32'h3F800000 + (32'(i) << 23) + 32'(i), 3'b000);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight discards them all.
        for (int i = 0; i < 3; i++) begin
            send($sformatf("rst_%0d", i), 1, 8'(130 + i), 0, 24'h800000, 3'b000, 32'h0, 3'b000);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_in_ready", in_ready, 1);
        exp_q.delete();
        tag_q.delete();
        n_snap = n_out;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_beat", n_out, n_snap);
        check("post_rst_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
